// File: rtl/sss_pkg.sv
// rtl/sss_pkg.sv - shared constants, state types and helpers for the SSS generator
package sss_pkg;

    localparam int SEQ_LEN  = 31;
    localparam int NID1_MAX = 167;

    // x(0..3)=0, x(4)=1; bit j of an LFSR window holds x(i+j)
    localparam logic [4:0] LFSR_SEED = 5'b10000;

    // Window taps producing x(i+5) for the s, c and z recurrences
    localparam logic [4:0] TAP_S = 5'b00101;
    localparam logic [4:0] TAP_C = 5'b01001;
    localparam logic [4:0] TAP_Z = 5'b10111;

    // Reference tables, bit i = x(i) (0 <=> +1, 1 <=> -1)
    localparam logic [30:0] GOLD_S = 31'b1010111_0110_0011_1110_0110_1001_0000;
    localparam logic [30:0] GOLD_C = 31'b1001011_0011_1110_0011_0111_0101_0000;
    localparam logic [30:0] GOLD_Z = 31'b1101010_0100_0101_1111_0110_0111_0000;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        BUILD
    } sss_state_t;

    typedef enum logic [2:0] {
        MI_IDLE,
        MI_QP,
        MI_Q,
        MI_M,
        MI_DONE
    } mindex_state_t;

    // Triangular number q(q+1)/2 without a multiplier
    function automatic logic [4:0] tri_num(input logic [2:0] q);
        logic [4:0] r;
        case (q)
            3'd0:    r = 5'd0;
            3'd1:    r = 5'd1;
            3'd2:    r = 5'd3;
            3'd3:    r = 5'd6;
            3'd4:    r = 5'd10;
            3'd5:    r = 5'd15;
            3'd6:    r = 5'd21;
            default: r = 5'd28;
        endcase
        return r;
    endfunction

    // Single compare-and-subtract reduction mod 31, valid for sums up to 61
    function automatic logic [4:0] wrap31(input logic [5:0] sum);
        logic [5:0] r;
        r = (sum >= 6'd31) ? (sum - 6'd31) : sum;
        return r[4:0];
    endfunction

endpackage

// File: rtl/sss_mindex.sv
// rtl/sss_mindex.sv - sequential subtractor deriving the m0/m1 cyclic shifts from N_ID_1
module sss_mindex
    import sss_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [7:0] i_n_id_1,
    output logic [4:0] o_m0,
    output logic [4:0] o_m1,
    output logic       o_valid
);

    mindex_state_t r_state;
    mindex_state_t w_state_next;
    logic [7:0]    r_n1;
    logic [7:0]    r_rem;
    logic [7:0]    w_rem_next;
    logic [2:0]    r_quo;
    logic [2:0]    w_quo_next;
    logic [4:0]    r_m0;
    logic [4:0]    r_m1;
    logic [4:0]    w_m0_next;
    logic [4:0]    w_m1_next;
    logic [7:0]    w_divisor;
    logic          w_ge;
    logic [7:0]    w_rem_sub;
    logic [2:0]    w_quo_inc;
    logic [5:0]    w_m1_sum;

    // One subtraction per cycle; a phase ends on the cycle its remainder drops below the divisor
    always_comb begin
        w_state_next = r_state;
        w_rem_next   = r_rem;
        w_quo_next   = r_quo;
        w_m0_next    = r_m0;
        w_m1_next    = r_m1;
        w_m1_sum     = 6'd0;
        w_divisor    = (r_state == MI_M) ? 8'd31 : 8'd30;
        w_ge         = (r_rem >= w_divisor);
        w_rem_sub    = w_ge ? (r_rem - w_divisor) : r_rem;
        w_quo_inc    = r_quo + {2'b00, w_ge};
        if (i_start) begin
            w_state_next = MI_QP;
            w_rem_next   = i_n_id_1;
            w_quo_next   = 3'd0;
        end else begin
            case (r_state)
                MI_QP, MI_Q: begin
                    if (w_rem_sub < 8'd30) begin
                        w_state_next = (r_state == MI_QP) ? MI_Q : MI_M;
                        w_rem_next   = r_n1 + {3'b000, tri_num(w_quo_inc)};
                        w_quo_next   = 3'd0;
                    end else begin
                        w_rem_next = w_rem_sub;
                        w_quo_next = w_quo_inc;
                    end
                end
                MI_M: begin
                    if (w_rem_sub < 8'd31) begin
                        w_m0_next    = w_rem_sub[4:0];
                        w_m1_sum     = {1'b0, w_rem_sub[4:0]} + {3'b000, w_quo_inc} + 6'd1;
                        w_m1_next    = wrap31(w_m1_sum);
                        w_state_next = MI_DONE;
                    end else begin
                        w_rem_next = w_rem_sub;
                        w_quo_next = w_quo_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Phase, remainder, quotient and result registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= MI_IDLE;
            r_n1    <= 8'd0;
            r_rem   <= 8'd0;
            r_quo   <= 3'd0;
            r_m0    <= 5'd0;
            r_m1    <= 5'd0;
        end else begin
            r_state <= w_state_next;
            r_rem   <= w_rem_next;
            r_quo   <= w_quo_next;
            r_m0    <= w_m0_next;
            r_m1    <= w_m1_next;
            if (i_start) begin
                r_n1 <= i_n_id_1;
            end
        end
    end

    assign o_m0    = r_m0;
    assign o_m1    = r_m1;
    assign o_valid = (r_state == MI_DONE);

endmodule

// File: rtl/sss_generator.sv
// rtl/sss_generator.sv - LTE secondary synchronisation signal generator (62-bit d(0..61))
module sss_generator
    import sss_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [7:0]  i_n_id_1,
    input  logic [1:0]  i_n_id_2,
    input  logic        i_subframe5,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [4:0]  o_m0,
    output logic [4:0]  o_m1,
    output logic [61:0] o_sss_out
);

    sss_state_t  r_state;
    sss_state_t  w_state_next;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        r_err_pend;
    logic        r_finish;
    logic [4:0]  r_m0;
    logic [4:0]  r_m1;
    logic [61:0] r_sss;
    logic [61:0] r_shadow;
    logic [1:0]  r_n2;
    logic        r_sf5;
    logic [4:0]  r_cnt;
    logic [4:0]  r_xs;
    logic [4:0]  r_xc;
    logic [4:0]  r_xz;
    logic [30:0] r_tab_s;
    logic [30:0] r_tab_c;
    logic [30:0] r_tab_z;

    logic        w_accept;
    logic        w_illegal;
    logic        w_mi_start;
    logic [4:0]  w_mi_m0;
    logic [4:0]  w_mi_m1;
    logic        w_mi_valid;
    logic        w_build_step;
    logic        w_xs_new;
    logic        w_xc_new;
    logic        w_xz_new;
    logic [4:0]  w_idx_s0;
    logic [4:0]  w_idx_s1;
    logic [4:0]  w_idx_c0;
    logic [4:0]  w_idx_c1;
    logic [4:0]  w_idx_za;
    logic [4:0]  w_idx_zb;
    logic        w_s0;
    logic        w_s1;
    logic        w_c0;
    logic        w_c1;
    logic        w_za;
    logic        w_zb;
    logic        w_d_even;
    logic        w_d_odd;

    // A start is only taken in IDLE while no run or error response is outstanding
    assign w_accept     = (r_state == IDLE) && i_start && !r_busy;
    assign w_illegal    = (i_n_id_1 > 8'(NID1_MAX)) || (i_n_id_2 == 2'd3);
    assign w_mi_start   = w_accept && !w_illegal;
    assign w_build_step = (r_state == BUILD) && w_mi_valid;

    sss_mindex u_mindex (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_start  (w_mi_start),
        .i_n_id_1 (i_n_id_1),
        .o_m0     (w_mi_m0),
        .o_m1     (w_mi_m1),
        .o_valid  (w_mi_valid)
    );

    // Next-state logic: GEN and BUILD each last 31 cycles counted by r_cnt
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_mi_start) w_state_next = GEN;
            GEN:     if (r_cnt == 5'd30) w_state_next = BUILD;
            BUILD:   if (w_build_step && (r_cnt == 5'd30)) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // LFSR feedback and the per-n table lookups, all indices reduced mod 31
    always_comb begin
        w_xs_new = ^(r_xs & TAP_S);
        w_xc_new = ^(r_xc & TAP_C);
        w_xz_new = ^(r_xz & TAP_Z);
        w_idx_s0 = wrap31({1'b0, r_cnt} + {1'b0, w_mi_m0});
        w_idx_s1 = wrap31({1'b0, r_cnt} + {1'b0, w_mi_m1});
        w_idx_c0 = wrap31({1'b0, r_cnt} + {4'b0000, r_n2});
        w_idx_c1 = wrap31({1'b0, r_cnt} + {4'b0000, r_n2} + 6'd3);
        w_idx_za = wrap31({1'b0, r_cnt} + {3'b000, w_mi_m0[2:0]});
        w_idx_zb = wrap31({1'b0, r_cnt} + {3'b000, w_mi_m1[2:0]});
        w_s0     = r_tab_s[w_idx_s0];
        w_s1     = r_tab_s[w_idx_s1];
        w_c0     = r_tab_c[w_idx_c0];
        w_c1     = r_tab_c[w_idx_c1];
        w_za     = r_tab_z[w_idx_za];
        w_zb     = r_tab_z[w_idx_zb];
        if (r_sf5) begin
            w_d_even = w_s1 ^ w_c0;
            w_d_odd  = w_s0 ^ w_c1 ^ w_zb;
        end else begin
            w_d_even = w_s0 ^ w_c0;
            w_d_odd  = w_s1 ^ w_c1 ^ w_za;
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture, table generation, shadow build and the done/err handshake
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_pend <= 1'b0;
            r_finish   <= 1'b0;
            r_m0       <= 5'd0;
            r_m1       <= 5'd0;
            r_sss      <= 62'd0;
            r_shadow   <= 62'd0;
            r_n2       <= 2'd0;
            r_sf5      <= 1'b0;
            r_cnt      <= 5'd0;
            r_xs       <= LFSR_SEED;
            r_xc       <= LFSR_SEED;
            r_xz       <= LFSR_SEED;
            r_tab_s    <= 31'd0;
            r_tab_c    <= 31'd0;
            r_tab_z    <= 31'd0;
        end else begin
            r_done <= 1'b0;

            if (w_accept) begin
                r_busy     <= 1'b1;
                r_err_pend <= w_illegal;
                r_n2       <= i_n_id_2;
                r_sf5      <= i_subframe5;
                r_cnt      <= 5'd0;
                r_xs       <= LFSR_SEED;
                r_xc       <= LFSR_SEED;
                r_xz       <= LFSR_SEED;
            end

            // Illegal inputs answer one cycle after capture, leaving results untouched
            if (r_err_pend) begin
                r_err_pend <= 1'b0;
                r_done     <= 1'b1;
                r_err      <= 1'b1;
                r_busy     <= 1'b0;
            end

            // Oldest bit x(i) falls out of the window into the top of each table;
            // after 31 shifts table bit i holds x(i)
            if (r_state == GEN) begin
                r_xs    <= {w_xs_new, r_xs[4:1]};
                r_xc    <= {w_xc_new, r_xc[4:1]};
                r_xz    <= {w_xz_new, r_xz[4:1]};
                r_tab_s <= {r_xs[0], r_tab_s[30:1]};
                r_tab_c <= {r_xc[0], r_tab_c[30:1]};
                r_tab_z <= {r_xz[0], r_tab_z[30:1]};
                r_cnt   <= (r_cnt == 5'd30) ? 5'd0 : (r_cnt + 5'd1);
            end

            // Pairs enter at the top, so pair n=0 ends up at bits 1:0
            if (w_build_step) begin
                r_shadow <= {w_d_odd, w_d_even, r_shadow[61:2]};
                r_cnt    <= (r_cnt == 5'd30) ? 5'd0 : (r_cnt + 5'd1);
                if (r_cnt == 5'd30) begin
                    r_finish <= 1'b1;
                end
            end

            if (r_finish) begin
                r_finish <= 1'b0;
                r_done   <= 1'b1;
                r_err    <= 1'b0;
                r_busy   <= 1'b0;
                r_sss    <= r_shadow;
                r_m0     <= w_mi_m0;
                r_m1     <= w_mi_m1;
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_m0      = r_m0;
    assign o_m1      = r_m1;
    assign o_sss_out = r_sss;

endmodule

// File: tb/tb_sss_generator.sv
// tb/tb_sss_generator.sv - self-checking bench for sss_generator against a behavioural SSS model
module tb_sss_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  n_id_1;
    logic [1:0]  n_id_2;
    logic        subframe5;
    logic        busy;
    logic        done;
    logic        err;
    logic [4:0]  m0;
    logic [4:0]  m1;
    logic [61:0] sss_out;

    int n_tests = 0;
    int n_fail  = 0;

    int ts [0:30];
    int tc [0:30];
    int tz [0:30];

    logic [61:0] last_sss;
    int          last_m0;
    int          last_m1;

    sss_generator dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_n_id_1    (n_id_1),
        .i_n_id_2    (n_id_2),
        .i_subframe5 (subframe5),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_m0        (m0),
        .o_m1        (m1),
        .o_sss_out   (sss_out)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic init_tables();
        int xs [0:30];
        int xc [0:30];
        int xz [0:30];
        for (int i = 0; i < 5; i++) begin
            xs[i] = (i == 4) ? 1 : 0;
            xc[i] = xs[i];
            xz[i] = xs[i];
        end
        for (int i = 0; i + 5 < 31; i++) begin
            xs[i+5] = (xs[i+2] + xs[i]) % 2;
            xc[i+5] = (xc[i+3] + xc[i]) % 2;
            xz[i+5] = (xz[i+4] + xz[i+2] + xz[i+1] + xz[i]) % 2;
        end
        for (int i = 0; i < 31; i++) begin
            ts[i] = xs[i];
            tc[i] = xc[i];
            tz[i] = xz[i];
        end
    endtask

    task automatic model(input int n1, input int n2, input bit sf5,
                         output logic [61:0] v, output int em0, output int em1);
        int qp, q, mp, s0, s1, c0, c1, za, zb;
        qp  = n1 / 30;
        q   = (n1 + qp * (qp + 1) / 2) / 30;
        mp  = n1 + q * (q + 1) / 2;
        em0 = mp % 31;
        em1 = (em0 + mp / 31 + 1) % 31;
        v   = '0;
        for (int n = 0; n < 31; n++) begin
            s0 = ts[(n + em0) % 31];
            s1 = ts[(n + em1) % 31];
            c0 = tc[(n + n2) % 31];
            c1 = tc[(n + n2 + 3) % 31];
            za = tz[(n + em0 % 8) % 31];
            zb = tz[(n + em1 % 8) % 31];
            if (!sf5) begin
                v[2*n]   = 1'((s0 + c0) % 2);
                v[2*n+1] = 1'((s1 + c1 + za) % 2);
            end else begin
                v[2*n]   = 1'((s1 + c0) % 2);
                v[2*n+1] = 1'((s0 + c1 + zb) % 2);
            end
        end
    endtask

    function automatic int corr(input logic [61:0] a, input logic [61:0] b);
        return 62 - 2 * $countones(a ^ b);
    endfunction

    // Issues one start and waits (bounded) for done; optionally disturbs inputs and start mid-run
    task automatic run_op(input int n1, input int n2, input bit sf5, input bit perturb,
                          output int lat, output bit busy_ok);
        n_id_1    = 8'(n1);
        n_id_2    = 2'(n2);
        subframe5 = sf5;
        start     = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        if (perturb) begin
            n_id_1    = 8'($urandom);
            n_id_2    = 2'($urandom);
            subframe5 = 1'($urandom);
        end
        while (!done && lat < 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            start = (perturb && lat == 10) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        if (busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        start = 0; n_id_1 = 0; n_id_2 = 0; subframe5 = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        last_sss = '0; last_m0 = 0; last_m1 = 0;
        n_tests++;
        if ({busy, done, err, m0, m1} !== 13'd0 || sss_out !== 62'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%0b done=%0b err=%0b m0=%0d m1=%0d sss=%h, want all zero",
                     busy, done, err, m0, m1, sss_out);
        end
    endtask

    task automatic test_basic();
        int lat, em0, em1; bit bok; logic [61:0] ev;
        run_op(0, 0, 0, 0, lat, bok);
        model(0, 0, 0, ev, em0, em1);
        n_tests++;
        if (lat !== 63) begin n_fail++; $display("FAIL basic latency: got %0d want 63", lat); end
        n_tests++;
        if (m0 !== 5'd0 || m1 !== 5'd1) begin
            n_fail++; $display("FAIL basic m0/m1: got %0d/%0d want 0/1", m0, m1);
        end
        n_tests++;
        if (sss_out !== ev) begin n_fail++; $display("FAIL basic sss: got %h want %h", sss_out, ev); end
        n_tests++;
        if (err !== 1'b0 || !bok) begin
            n_fail++; $display("FAIL basic err/busy: err=%0b busy_ok=%0b want 0/1", err, bok);
        end
        last_sss = ev; last_m0 = em0; last_m1 = em1;
    endtask

    task automatic test_n1_167();
        int lat, em0, em1, bad; bit bok; logic [61:0] ev, v5, v0;
        run_op(167, 2, 1, 0, lat, bok);
        model(167, 2, 1, ev, em0, em1);
        v5 = sss_out;
        n_tests++;
        if (m0 !== 5'd2 || m1 !== 5'd9) begin
            n_fail++; $display("FAIL n167 m0/m1: got %0d/%0d want 2/9", m0, m1);
        end
        n_tests++;
        if (sss_out !== ev || lat !== 63) begin
            n_fail++; $display("FAIL n167 sf5 sss: got %h lat %0d want %h lat 63", sss_out, lat, ev);
        end
        run_op(167, 2, 0, 0, lat, bok);
        v0 = sss_out;
        bad = 0;
        for (int n = 0; n < 31; n++) begin
            if ((v5[2*n] ^ v0[2*n]) !== 1'((ts[(n + 2) % 31] + ts[(n + 9) % 31]) % 2)) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL n167 even-bit swap: %0d bits wrong, want 0", bad); end
        model(167, 2, 0, last_sss, last_m0, last_m1);
    endtask

    task automatic test_illegal();
        int lat; bit bok;
        int n1s [3] = '{168, 10, 255};
        int n2s [3] = '{0, 3, 1};
        for (int i = 0; i < 3; i++) begin
            run_op(n1s[i], n2s[i], 0, 0, lat, bok);
            n_tests++;
            if (lat !== 1 || err !== 1'b1 || !bok) begin
                n_fail++;
                $display("FAIL illegal %0d: lat=%0d err=%0b busy_ok=%0b want 1/1/1", i, lat, err, bok);
            end
            n_tests++;
            if (sss_out !== last_sss || m0 !== 5'(last_m0) || m1 !== 5'(last_m1)) begin
                n_fail++;
                $display("FAIL illegal %0d hold: sss=%h m=%0d/%0d want %h m=%0d/%0d",
                         i, sss_out, m0, m1, last_sss, last_m0, last_m1);
            end
        end
    endtask

    task automatic test_abort();
        int lat, em0, em1; bit bok, saw_done; logic [61:0] ev;
        saw_done = 0;
        n_id_1 = 8'd45; n_id_2 = 2'd1; subframe5 = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (done) saw_done = 1; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 35; i++) begin @(posedge clk); #1; if (done) saw_done = 1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || m0 !== 5'd0 || m1 !== 5'd0 || sss_out !== 62'd0) begin
            n_fail++;
            $display("FAIL abort outputs: busy=%0b done=%0b err=%0b m=%0d/%0d sss=%h want all zero",
                     busy, done, err, m0, m1, sss_out);
        end
        for (int i = 0; i < 70; i++) begin @(posedge clk); #1; if (done || busy) saw_done = 1; end
        n_tests++;
        if (saw_done) begin n_fail++; $display("FAIL abort: done/busy seen after abort, want none"); end
        last_sss = '0; last_m0 = 0; last_m1 = 0;
        run_op(100, 1, 1, 0, lat, bok);
        model(100, 1, 1, ev, em0, em1);
        n_tests++;
        if (sss_out !== ev || lat !== 63) begin
            n_fail++; $display("FAIL abort recovery: got %h lat %0d want %h lat 63", sss_out, lat, ev);
        end
        last_sss = ev; last_m0 = em0; last_m1 = em1;
    endtask

    task automatic test_back_to_back();
        int lat, lat2, em0, em1; bit bok; logic [61:0] ev;
        run_op(29, 0, 0, 0, lat, bok);
        n_id_1 = 8'd151; n_id_2 = 2'd2; subframe5 = 1'b1; start = 1'b1;
        lat2 = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            lat2++;
        end while (!done && lat2 < 200);
        model(151, 2, 1, ev, em0, em1);
        n_tests++;
        if (lat2 !== 64) begin n_fail++; $display("FAIL b2b spacing: got %0d want 64", lat2); end
        n_tests++;
        if (sss_out !== ev || m0 !== 5'(em0) || m1 !== 5'(em1)) begin
            n_fail++; $display("FAIL b2b result: got %h m=%0d/%0d want %h m=%0d/%0d", sss_out, m0, m1, ev, em0, em1);
        end
        last_sss = ev; last_m0 = em0; last_m1 = em1;
    endtask

    task automatic test_random();
        int lat, em0, em1, n1, n2; bit bok, sf, legal; logic [61:0] ev;
        for (int r = 0; r < 30; r++) begin
            n1 = (($urandom % 8) == 0) ? int'($urandom_range(168, 255)) : int'($urandom_range(0, 167));
            n2 = (($urandom % 8) == 0) ? 3 : int'($urandom_range(0, 2));
            sf = 1'($urandom);
            legal = (n1 <= 167) && (n2 != 3);
            run_op(n1, n2, sf, 1, lat, bok);
            if (legal) model(n1, n2, sf, ev, em0, em1);
            else begin ev = last_sss; em0 = last_m0; em1 = last_m1; end
            n_tests++;
            if (lat !== (legal ? 63 : 1) || err !== !legal || !bok || sss_out !== ev ||
                m0 !== 5'(em0) || m1 !== 5'(em1)) begin
                n_fail++;
                $display("FAIL random n1=%0d n2=%0d sf=%0b: lat=%0d err=%0b sss=%h m=%0d/%0d want lat=%0d err=%0b sss=%h m=%0d/%0d",
                         n1, n2, sf, lat, err, sss_out, m0, m1, legal ? 63 : 1, !legal, ev, em0, em1);
            end
            last_sss = ev; last_m0 = em0; last_m1 = em1;
        end
    endtask

    task automatic test_sweep();
        int lat, em0, em1, c; bit bok; logic [61:0] ev;
        logic [61:0] prev [2];
        bit          have_prev [2];
        have_prev[0] = 0; have_prev[1] = 0;
        for (int n2 = 0; n2 < 3; n2++) begin
            for (int n1 = 0; n1 <= 167; n1++) begin
                for (int sf = 0; sf < 2; sf++) begin
                    run_op(n1, n2, 1'(sf), 0, lat, bok);
                    model(n1, n2, 1'(sf), ev, em0, em1);
                    c = corr(sss_out, ev);
                    n_tests++;
                    if (c != 62 || lat != 63 || err !== 1'b0 || m0 !== 5'(em0) || m1 !== 5'(em1)) begin
                        n_fail++;
                        $display("FAIL sweep n1=%0d n2=%0d sf=%0d: corr=%0d lat=%0d err=%0b m=%0d/%0d want 62/63/0 m=%0d/%0d",
                                 n1, n2, sf, c, lat, err, m0, m1, em0, em1);
                    end
                    if (have_prev[sf]) begin
                        c = corr(sss_out, prev[sf]);
                        n_tests++;
                        if (c >= 62) begin
                            n_fail++;
                            $display("FAIL sweep distinct n1=%0d n2=%0d sf=%0d: corr=%0d want <62", n1, n2, sf, c);
                        end
                    end
                    prev[sf] = sss_out;
                    have_prev[sf] = 1;
                end
            end
        end
    endtask

    initial begin
        init_tables();
        test_reset();
        test_basic();
        test_n1_167();
        test_illegal();
        test_abort();
        test_back_to_back();
        test_random();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
